cntr_timer_arbiter: RTL and testbench

- Round-robin controller that shares one N-bit universal up/down counter between NREQ requesters.
- Each requester asks for a timed interval of `dur` counts, counting up or down. The block grants one requester at a time, loads and enables the counter, detects the terminal count, pulses `done`, then clears the counter.
- Sits between requester logic and a single counter instance. It drives the counter's `syn_n_clr`/`en`/`up`/`load`/`D` controls and consumes its `Q`/`max_tick`/`min_tick`.

---
 rtl/cntr_timer_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_cntr_timer_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_timer_arbiter.sv
// cntr_timer_arbiter: round-robin controller sharing one N-bit up/down counter
// between NREQ requesters. Each grant loads the counter, runs it to the
// requested duration, pulses done and then clears the counter.
// Optional build macro CNTR_TIMER_PAUSE_EN adds a 'pause' input that freezes
// the counter while in RUN.
module cntr_timer_arbiter #(
    parameter int N    = 4,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] dur_flat,
    input  logic [NREQ-1:0]   dir,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cnt_syn_n_clr,
    output logic              cnt_en,
    output logic              cnt_up,
    output logic              cnt_load,
    output logic [N-1:0]      cnt_D,
    input  logic [N-1:0]      cnt_Q,
    input  logic              cnt_max_tick,
    input  logic              cnt_min_tick
`ifdef CNTR_TIMER_PAUSE_EN
    ,
    input  logic              pause
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [N-1:0]    dur_q, dur_d;
    logic            dir_q, dir_d;
    logic            abort_q, abort_d;

    logic            pause_w;
    logic [N-1:0]    dur_arr [NREQ];
    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   sel_try;
    int              cand;
    logic            terminal;
    logic            req_lost;

`ifdef CNTR_TIMER_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // Split the flat duration bus into one slice per requester.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_dur
            assign dur_arr[gi] = dur_flat[gi*N +: N];
        end
    endgenerate

    // Up mode stops when the count equals the target, down mode at zero.
    assign terminal = dir_q ? (cnt_Q == dur_q) : cnt_min_tick;
    // The granted requester withdrew its request.
    assign req_lost = ~|(req & gnt_q);

    // Pick the first asserted requester at or after the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_try   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand    = (int'(ptr_q) + i) % NREQ;
            sel_try = PW'(cand);
            if (!sel_found && req[sel_try]) begin
                sel_found = 1'b1;
                sel_idx   = sel_try;
            end
        end
    end

    // State register plus latched grant context; asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            dur_q   <= '0;
            dir_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            dur_q   <= dur_d;
            dir_q   <= dir_d;
            abort_q <= abort_d;
        end
    end

    // Next-state logic and state-decoded counter controls.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        gnt_d         = gnt_q;
        dur_d         = dur_q;
        dir_d         = dir_q;
        abort_d       = abort_q;
        gnt           = gnt_q;
        done          = '0;
        busy          = (state_q != IDLE);
        cnt_syn_n_clr = 1'b1;
        cnt_en        = 1'b0;
        cnt_up        = 1'b0;
        cnt_load      = 1'b0;
        cnt_D         = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                    dur_d   = dur_arr[sel_idx];
                    dir_d   = dir[sel_idx];
                    abort_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                cnt_D    = dir_q ? '0 : dur_q;
                if (req_lost) begin
                    abort_d = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_up = dir_q;
                // Enable is dropped in the terminal cycle so the counter holds the target.
                cnt_en = !terminal && !pause_w;
                if (terminal) begin
                    state_d = FIN;
                end
                if (req_lost) begin
                    abort_d = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                cnt_syn_n_clr = 1'b0;
                done          = abort_q ? '0 : gnt_q;
                ptr_d         = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
                gnt_d         = '0;
                abort_d       = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Up mode must never run the counter into its maximum (no wrap).
    a_no_wrap: assert property (@(posedge clk) disable iff (!n_reset)
        !(cnt_en && cnt_up && cnt_max_tick));
    // Load never coincides with clear or enable.
    a_load_clr: assert property (@(posedge clk) disable iff (!n_reset)
        !(cnt_load && !cnt_syn_n_clr));
    a_load_en: assert property (@(posedge clk) disable iff (!n_reset)
        !(cnt_load && cnt_en));

endmodule

// File: tb/tb_cntr_timer_arbiter.sv
// Testbench for cntr_timer_arbiter with a behavioural counter model and a
// scoreboard of expected transactions checked at each FIN cycle.
module tb_cntr_timer_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [3:0]  req;
    logic [15:0] dur_flat;
    logic [3:0]  dir;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        cnt_syn_n_clr;
    logic        cnt_en;
    logic        cnt_up;
    logic        cnt_load;
    logic [3:0]  cnt_D;
    logic [3:0]  cnt_Q;
    logic        cnt_max_tick;
    logic        cnt_min_tick;
`ifdef CNTR_TIMER_PAUSE_EN
    logic        pause;
`endif

    cntr_timer_arbiter #(.N(4), .NREQ(4)) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .req           (req),
        .dur_flat      (dur_flat),
        .dir           (dir),
        .gnt           (gnt),
        .done          (done),
        .busy          (busy),
        .cnt_syn_n_clr (cnt_syn_n_clr),
        .cnt_en        (cnt_en),
        .cnt_up        (cnt_up),
        .cnt_load      (cnt_load),
        .cnt_D         (cnt_D),
        .cnt_Q         (cnt_Q),
        .cnt_max_tick  (cnt_max_tick),
        .cnt_min_tick  (cnt_min_tick)
`ifdef CNTR_TIMER_PAUSE_EN
        ,
        .pause         (pause)
`endif
    );

    always #5 clk = ~clk;

    // Universal up/down counter model driven by the DUT controls.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset)            cnt_Q <= 4'd0;
        else if (!cnt_syn_n_clr) cnt_Q <= 4'd0;
        else if (cnt_load)       cnt_Q <= cnt_D;
        else if (cnt_en)         cnt_Q <= cnt_up ? cnt_Q + 4'd1 : cnt_Q - 4'd1;
    end
    assign cnt_max_tick = (cnt_Q == 4'hF);
    assign cnt_min_tick = (cnt_Q == 4'h0);

    typedef struct {
        logic [3:0] gnt;
        int         lat;
        logic [3:0] done;
        int         d;
        int         en;   // -1: not checked
        int         q;    // -1: not checked
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   rise_cyc = 0;
    int   en_cnt   = 0;
    logic [3:0] prev_gnt = 4'd0;
    logic       prev_fin = 1'b0;

    task automatic check_val(input string tag, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic push(input logic [3:0] g, input int lat, input logic [3:0] dn,
                        input int d, input int en, input int q);
        exp_t x;
        x.gnt = g; x.lat = lat; x.done = dn; x.d = d; x.en = en; x.q = q;
        sb_q.push_back(x);
    endtask

    task automatic wait_empty(input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check_val("sb_drained", sb_q.size(), 0);
        sb_q.delete();
        #1;
    endtask

    task automatic wait_load(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (!cnt_load && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_val("load_seen", int'(cnt_load), 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: LOAD and FIN checks against the scoreboard, one line per transaction.
    always @(negedge clk) begin
        if (n_reset) begin
            if (prev_fin) begin
                check_val("idle_done", int'(done), 0);
                check_val("idle_gnt", int'(gnt), 0);
                check_val("idle_busy", int'(busy), 0);
            end
            if (gnt != 4'd0 && prev_gnt == 4'd0) begin
                rise_cyc = cyc;
                en_cnt   = 0;
            end
            if (cnt_en) en_cnt++;
            if (cnt_load && sb_q.size() > 0) begin
                check_val("load_d", int'(cnt_D), sb_q[0].d);
                check_val("load_excl", int'({cnt_en, ~cnt_syn_n_clr}), 0);
            end
            if (!cnt_syn_n_clr) begin
                check_val("sb_nonempty", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_val("fin_gnt", int'(gnt), int'(e.gnt));
                    check_val("fin_done", int'(done), int'(e.done));
                    check_val("latency", cyc - rise_cyc, e.lat);
                    if (e.en >= 0) check_val("en_cycles", en_cnt, e.en);
                    if (e.q >= 0)  check_val("fin_q", int'(cnt_Q), e.q);
                    $display("txn gnt=%b done=%b latency=%0d en_cycles=%0d q=%0d",
                             gnt, done, cyc - rise_cyc, en_cnt, cnt_Q);
                end
                prev_fin <= 1'b1;
            end else begin
                prev_fin <= 1'b0;
            end
            prev_gnt <= gnt;
        end else begin
            prev_gnt <= 4'd0;
            prev_fin <= 1'b0;
        end
    end

    initial begin
        n_reset  = 1'b0;
        req      = 4'd0;
        dur_flat = 16'd0;
        dir      = 4'd0;
`ifdef CNTR_TIMER_PAUSE_EN
        pause    = 1'b0;
`endif
        #1;
        check_val("rst_gnt", int'(gnt), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_clr_n", int'(cnt_syn_n_clr), 1);
        check_val("rst_en", int'(cnt_en), 0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        @(posedge clk); #1;

        // Up, dur=0 on requester 1
        dur_flat[7:4] = 4'd0; dir[1] = 1'b1;
        push(4'b0010, 2, 4'b0010, 0, 0, 0);
        req = 4'b0010;
        wait_empty(50);
        req = 4'd0;

        // Up, dur=15 on requester 1: must stop at max without wrapping
        @(posedge clk); #1;
        dur_flat[7:4] = 4'd15;
        push(4'b0010, 17, 4'b0010, 0, 15, 15);
        req = 4'b0010;
        wait_empty(60);
        req = 4'd0;

        // Down, dur=5 on requester 2
        @(posedge clk); #1;
        dur_flat[11:8] = 4'd5; dir[2] = 1'b0;
        push(4'b0100, 7, 4'b0100, 5, 5, 0);
        req = 4'b0100;
        wait_empty(50);
        req = 4'd0;

        // Abort: requester 3 withdraws on the second RUN cycle
        @(posedge clk); #1;
        dur_flat[15:12] = 4'd5; dir[3] = 1'b0;
        push(4'b1000, 3, 4'b0000, 5, -1, -1);
        req = 4'b1000;
        wait_load(20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 4'd0;
        wait_empty(20);

        // Round-robin with all requesting, pointer starts at 0 after the abort
        @(posedge clk); #1;
        dur_flat = 16'h1111; dir = 4'b0000;
        push(4'b0001, 3, 4'b0001, 1, 1, 0);
        push(4'b0010, 3, 4'b0010, 1, 1, 0);
        push(4'b0100, 3, 4'b0100, 1, 1, 0);
        push(4'b1000, 3, 4'b1000, 1, 1, 0);
        push(4'b0001, 3, 4'b0001, 1, 1, 0);
        req = 4'b1111;
        wait_empty(100);
        req = 4'd0;

`ifdef CNTR_TIMER_PAUSE_EN
        // Pause for 3 RUN cycles on a dur=4 down count
        @(posedge clk); #1;
        dur_flat[3:0] = 4'd4; dir[0] = 1'b0;
        push(4'b0001, 9, 4'b0001, 4, 4, 0);
        req = 4'b0001;
        wait_load(20);
        @(posedge clk); #1 pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
        wait_empty(40);
        req = 4'd0;
`endif

        // Asynchronous reset asserted mid-RUN
        @(posedge clk); #1;
        dur_flat[3:0] = 4'd5; dir[0] = 1'b0;
        req = 4'b0001;
        wait_load(20);
        @(posedge clk); #1;
        @(posedge clk); #3;
        check_val("pre_rst_busy", int'(busy), 1);
        n_reset = 1'b0;
        #1;
        check_val("async_gnt", int'(gnt), 0);
        check_val("async_busy", int'(busy), 0);
        check_val("async_en", int'(cnt_en), 0);
        check_val("async_clr_n", int'(cnt_syn_n_clr), 1);
        req = 4'd0;
        @(posedge clk); #1 n_reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", int'(busy), 0);
        check_val("post_rst_gnt", int'(gnt), 0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
